// File: rtl/loader_pkg.sv
// Shared loader definitions: FSM state encoding, default memory depths and byte strides.
// Build option LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum beat.
// Pure definitions; no timing or flow-control behaviour of its own.
package loader_pkg;

  localparam int IMEM_WORDS_DEF = 512;
  localparam int DMEM_WORDS_DEF = 1024;
  localparam int IMEM_STRIDE    = 4;
  localparam int DMEM_STRIDE    = 8;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, CHECK, RUN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, ERR} state_t;
`endif

  // Byte address of word idx in a memory whose words are stride bytes wide.
  function automatic logic [63:0] byte_addr(input logic [10:0] idx, input int stride);
    return 64'(idx) * 64'(stride);
  endfunction

endpackage

// File: rtl/cpu_loader_if.sv
// Load stream carrying instruction and data words into the loader.
// Zero latency; pure wiring.
// A beat moves only when s_valid and s_ready are both high.
interface cpu_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/loader_wr_port.sv
// Registered write port for one memory: address, data and single-cycle write enable.
// One cycle from wr_req to wen; wen is high for exactly one cycle per request.
// No backpressure: the memory external port always accepts a write.
module loader_wr_port
  import loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [10:0]       wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [63:0]       addr,
  output logic              wen,
  output logic [DATA_W-1:0] wdata
);

  // Capture the write; reset drops any write requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      wen   <= 1'b0;
      wdata <= '0;
    end else begin
      wen <= wr_req;
      if (wr_req) begin
        addr  <= byte_addr(wr_idx, STRIDE);
        wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/cpu_loader.sv
// Streams instruction then data words into the CPU memories, then enables the CPU.
// Write pulse one cycle after each beat; cpu_enable rises two cycles after the final beat.
// s_ready high only while loading; optional LOADER_CHECKSUM_EN appends a checksum beat.
module cpu_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [9:0]   imem_cnt,
  input  logic [10:0]  dmem_cnt,
  input  logic         halt,
  cpu_loader_if.slave  s,
  output logic [63:0]  addr_ext,
  output logic         wen_ext,
  output logic [31:0]  wdata_ext,
  output logic [63:0]  addr_ext_2,
  output logic         wen_ext_2,
  output logic [63:0]  wdata_ext_2,
  output logic         cpu_enable,
  output logic         busy,
  output logic         done,
  output logic         error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;
`else
  localparam state_t AFTER_LOAD = RUN;
`endif

  state_t      state, state_nxt;
  logic [9:0]  icnt_q, icnt_nxt;
  logic [10:0] dcnt_q, dcnt_nxt;
  logic [10:0] idx, idx_nxt;
  logic        wr_i, wr_d;
  logic        stream_phase, fire;
  logic        last_i, last_d;
  logic        final_i, final_d;
`ifdef LOADER_CHECKSUM_EN
  logic [63:0] csum_q, csum_nxt;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign stream_phase = (state == LOAD_I) || (state == LOAD_D) || (state == CHECK);
  // The checksum beat carries s_last, so no data beat is ever the final one.
  assign final_i = 1'b0;
  assign final_d = 1'b0;
`else
  assign stream_phase = (state == LOAD_I) || (state == LOAD_D);
  assign final_i = last_i && (dcnt_q == '0);
  assign final_d = last_d;
`endif

  assign s.s_ready = stream_phase;
  assign busy      = stream_phase;
  assign error     = (state == ERR);
  assign fire      = s.s_valid && stream_phase;
  assign last_i    = (idx + 11'd1) == {1'b0, icnt_q};
  assign last_d    = (idx + 11'd1) == dcnt_q;

  // State, latched counts, word index and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      icnt_q <= '0;
      dcnt_q <= '0;
      idx    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state  <= state_nxt;
      icnt_q <= icnt_nxt;
      dcnt_q <= dcnt_nxt;
      idx    <= idx_nxt;
`ifdef LOADER_CHECKSUM_EN
      csum_q <= csum_nxt;
`endif
    end
  end

  // Next state, index stepping and write requests; a beat with a misplaced s_last is not written.
  always_comb begin
    state_nxt = state;
    icnt_nxt  = icnt_q;
    dcnt_nxt  = dcnt_q;
    idx_nxt   = idx;
    wr_i      = 1'b0;
    wr_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_nxt  = csum_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          icnt_nxt = imem_cnt;
          dcnt_nxt = dmem_cnt;
          idx_nxt  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_nxt = '0;
`endif
          if (int'(imem_cnt) > IMEM_WORDS || int'(dmem_cnt) > DMEM_WORDS) state_nxt = ERR;
          else if (imem_cnt != '0)                                       state_nxt = LOAD_I;
          else if (dmem_cnt != '0)                                       state_nxt = LOAD_D;
          else                                                           state_nxt = RUN;
        end
      end
      LOAD_I: begin
        if (fire) begin
          if (s.s_last != final_i) begin
            state_nxt = ERR;
          end else begin
            wr_i = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_nxt = csum_q ^ {32'h0, s.s_data[31:0]};
`endif
            if (last_i) begin
              idx_nxt   = '0;
              state_nxt = (dcnt_q != '0) ? LOAD_D : AFTER_LOAD;
            end else begin
              idx_nxt = idx + 11'd1;
            end
          end
        end
      end
      LOAD_D: begin
        if (fire) begin
          if (s.s_last != final_d) begin
            state_nxt = ERR;
          end else begin
            wr_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_nxt = csum_q ^ s.s_data;
`endif
            if (last_d) begin
              idx_nxt   = '0;
              state_nxt = AFTER_LOAD;
            end else begin
              idx_nxt = idx + 11'd1;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire) state_nxt = (s.s_last && (s.s_data == csum_q)) ? RUN : ERR;
      end
`endif
      RUN: begin
        if (halt) state_nxt = IDLE;
      end
      ERR: state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // CPU enable follows RUN one cycle late so the final write lands first; done marks the rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      cpu_enable <= (state == RUN) && !halt;
      done       <= (state == RUN) && !cpu_enable && !halt;
    end
  end

  loader_wr_port #(.DATA_W(32), .STRIDE(IMEM_STRIDE)) u_wr_imem (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_i),
    .wr_idx  (idx),
    .wr_data (s.s_data[31:0]),
    .addr    (addr_ext),
    .wen     (wen_ext),
    .wdata   (wdata_ext)
  );

  loader_wr_port #(.DATA_W(64), .STRIDE(DMEM_STRIDE)) u_wr_dmem (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_d),
    .wr_idx  (idx),
    .wr_data (s.s_data),
    .addr    (addr_ext_2),
    .wen     (wen_ext_2),
    .wdata   (wdata_ext_2)
  );

endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: table of load scenarios plus reset and checksum sequences.
// Expected memory writes are queued as beats are driven and matched as write pulses appear.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_loader;
  import loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, halt;
  logic [9:0]  imem_cnt;
  logic [10:0] dmem_cnt;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;
  logic        wen_ext, wen_ext_2, cpu_enable, busy, done, error;

  cpu_loader_if s_if ();

  cpu_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_cnt    (imem_cnt),
    .dmem_cnt    (dmem_cnt),
    .halt        (halt),
    .s           (s_if),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int          icnt;
    int          dcnt;
    int          last_at;     // beat index carrying s_last; -1 means the final beat
    logic [63:0] base;
    bit          hold_start;
    bit          exp_err;
  } row_t;

  wr_t  exp_q[$];
  row_t rows[10];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   wr_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_match(input bit port, input logic [63:0] addr, input logic [63:0] data);
    wr_t e;
    wr_seen++;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write port=%0d addr=%h data=%h required=no write", port, addr, data);
    end else begin
      e = exp_q.pop_front();
      chk("wr_port", 64'(port), 64'(e.port));
      chk("wr_addr", addr, e.addr);
      chk("wr_data", data, e.data);
    end
  endtask

  // Write monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wen_ext || wen_ext_2) chk("wen_exclusive", 64'(wen_ext & wen_ext_2), 64'd0);
    if (wen_ext)   sb_match(1'b0, addr_ext, {32'h0, wdata_ext});
    if (wen_ext_2) sb_match(1'b1, addr_ext_2, wdata_ext_2);
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input bit last, input bit exp_wr,
                           input bit port, input logic [63:0] addr, input logic [63:0] edata);
    int n;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = last;
    if (exp_wr) exp_q.push_back('{port, addr, edata});
    n = 0;
    while (!s_if.s_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!s_if.s_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=s_ready low required=s_ready high");
    end
    @(negedge clk);
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_row(input row_t r);
    int ndata, total, lpos, nsend, nwr, e;
    bit size_err, port;
    logic [63:0] csum, d, addr, edata;
    ndata    = r.icnt + r.dcnt;
    total    = (ndata == 0) ? 0 : ndata + CS;
    size_err = (r.icnt > 512) || (r.dcnt > 1024);
    lpos     = (r.last_at < 0) ? total - 1 : r.last_at;
    if (size_err || total == 0) begin
      nsend = 0;
      nwr   = 0;
    end else if (lpos == total - 1) begin
      nsend = total;
      nwr   = ndata;
    end else begin
      e     = (lpos < total - 1) ? lpos : total - 1;
      nsend = e + 1;
      nwr   = (e < ndata) ? e : ndata;
    end
    done_cnt = 0;
    wr_seen  = 0;
    csum     = '0;
    start    = 1'b1;
    imem_cnt = r.icnt[9:0];
    dmem_cnt = r.dcnt[10:0];
    @(negedge clk);
    start = r.hold_start;
    if (r.hold_start) begin
      imem_cnt = 10'd1;
      dmem_cnt = 11'd0;
    end
    for (int k = 0; k < nsend; k++) begin
      if (k < ndata) d = r.base + 64'h1_0000_0001 * 64'(k);
      else           d = csum;
      if (k < r.icnt) begin
        port  = 1'b0;
        addr  = 64'(4 * k);
        edata = {32'h0, d[31:0]};
      end else begin
        port  = 1'b1;
        addr  = 64'(8 * (k - r.icnt));
        edata = d;
      end
      if (k < ndata) csum = csum ^ edata;
      send_beat(d, k == lpos, k < nwr, port, addr, edata);
    end
    start = 1'b0;
    if (!r.exp_err) begin
      chk("en_low_at_last_wr", 64'(cpu_enable), 64'd0);
      if (CS == 0 && ndata > 0) chk("last_wr_pulse", 64'(wen_ext | wen_ext_2), 64'd1);
      @(negedge clk);
      chk("en_rise", 64'(cpu_enable), 64'd1);
      chk("done_pulse", 64'(done), 64'd1);
      @(negedge clk);
      chk("done_single", 64'(done), 64'd0);
      chk("en_hold", 64'(cpu_enable), 64'd1);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      chk("halt_clears_en", 64'(cpu_enable), 64'd0);
      chk("idle_not_busy", 64'({busy, s_if.s_ready, error}), 64'd0);
      chk("done_count", 64'(done_cnt), 64'd1);
    end else begin
      chk("err_flag", 64'(error), 64'd1);
      chk("err_en_low", 64'(cpu_enable), 64'd0);
      chk("err_not_busy", 64'(busy), 64'd0);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      @(negedge clk);
      chk("err_sticky_halt", 64'({error, cpu_enable}), 64'b10);
      chk("err_no_done", 64'(done_cnt), 64'd0);
    end
    chk("write_count", 64'(wr_seen), 64'(nwr));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    do_reset();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic cs_seq(input logic [63:0] cval, input bit exp_err);
    start    = 1'b1;
    imem_cnt = 10'd0;
    dmem_cnt = 11'd2;
    @(negedge clk);
    start = 1'b0;
    send_beat(64'd1, 1'b0, 1'b1, 1'b1, 64'd0, 64'd1);
    send_beat(64'd2, 1'b0, 1'b1, 1'b1, 64'd8, 64'd2);
    send_beat(cval, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("cs_error", 64'(error), 64'(exp_err));
    chk("cs_enable", 64'(cpu_enable), 64'(!exp_err));
    do_reset();
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    halt = 1'b0;
    imem_cnt = '0;
    dmem_cnt = '0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;

    rows[0] = '{3,    2,    -1, 64'h1111_2222_0000_0010, 1'b0, 1'b0};
    rows[1] = '{0,    1,    -1, 64'hDEADBEEF_00000001,   1'b0, 1'b0};
    rows[2] = '{2,    2,     1, 64'hA5A5_0000_0000_0100, 1'b0, 1'b1};
    rows[3] = '{513,  0,    -1, 64'h0,                   1'b0, 1'b1};
    rows[4] = '{0,    0,    -1, 64'h0,                   1'b0, 1'b0};
    rows[5] = '{1,    1,    99, 64'h0F0F_0000_0000_0200, 1'b0, 1'b1};
    rows[6] = '{4,    3,    -1, 64'h7777_0000_CAFE_0000, 1'b1, 1'b0};
    rows[7] = '{0,    1025, -1, 64'h0,                   1'b0, 1'b1};
    rows[8] = '{512,  0,    -1, 64'h3333_0000_1000_0000, 1'b0, 1'b0};
    rows[9] = '{0,    1024, -1, 64'h4444_5555_0000_0000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(|{addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2, wdata_ext_2,
                              cpu_enable, busy, done, error, s_if.s_ready}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_row(rows[i]);

    // Reset in the middle of a load: the pending write is dropped, then a fresh load restarts at 0.
    wr_seen  = 0;
    start    = 1'b1;
    imem_cnt = 10'd3;
    dmem_cnt = 11'd0;
    @(negedge clk);
    start = 1'b0;
    send_beat(64'h0000_0000_AAAA_0001, 1'b0, 1'b1, 1'b0, 64'd0, 64'h0000_0000_AAAA_0001);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 64'h0000_0000_BBBB_0002;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_if.s_valid = 1'b0;
    chk("rst_mid_outputs", 64'(|{addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2, wdata_ext_2,
                                cpu_enable, busy, done, error, s_if.s_ready}), 64'd0);
    @(negedge clk);
    chk("rst_mid_writes", 64'(wr_seen), 64'd1);
    run_row('{3, 0, -1, 64'h0000_0000_CCCC_0000, 1'b0, 1'b0});

`ifdef LOADER_CHECKSUM_EN
    cs_seq(64'd3, 1'b0);
    cs_seq(64'd4, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
